lp_grid_solver: RTL and testbench

//  Parametrised 2-variable integer linear-program solver. It solves max or min of c1*x1+c2*x2 over an integer box.
//  The box is defined by 4 bound constraints plus up to MAX_GEN general constraints a1*x1+a2*x2<=b.
//  It enumerates every lattice point in the box, one point per cycle, and reports the optimum value and the argument that reaches it.
//  The feasible, infeasible and overflow cases each have their own status flag.

---
 rtl/lp_grid_solver.sv | 144 ++++++++++++++
 tb/tb_lp_grid_solver.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/lp_grid_solver.sv
// lp_grid_solver: exhaustive 2-variable integer LP solver over a bounded box
// with up to MAX_GEN general constraints, one lattice point per cycle.
module lp_grid_solver #(
   parameter int CW = 6,
   parameter int BW = 12,
   parameter int MAX_GEN = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   input  logic                    in_mode,
   input  logic signed [CW-1:0]    in_a1,
   input  logic signed [CW-1:0]    in_a2,
   input  logic signed [BW-1:0]    in_b,
   output logic                    out_valid,
   output logic                    out_feasible,
   output logic                    out_overflow,
   output logic signed [CW+BW+1:0] out_value,
   output logic signed [BW-1:0]    out_x1,
   output logic signed [BW-1:0]    out_x2
);
   localparam int OW = CW + BW + 2;
   localparam int NW = $clog2(MAX_GEN + 1);
   localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, SCAN = 2'd2, DONE = 2'd3;
   logic [1:0] state;
   logic mode, found, ovf;
   logic signed [CW-1:0] c1, c2;
   logic signed [BW-1:0] x1_lo, x1_hi, x2_lo, x2_hi, x1, x2, bx1, bx2, p1, p2, nx1, nx2;
   logic signed [OW-1:0] obj, best;
   logic [NW-1:0] cnt;
   logic [MAX_GEN-1:0] ok;
   logic inv, eval, last, take, full, gen, wr, b_x1h, b_x1l, b_x2h, b_x2l;
   assign b_x1h = in_a1 == CW'(1) && in_a2 == '0;
   assign b_x1l = in_a1 == '1 && in_a2 == '0;
   assign b_x2h = in_a1 == '0 && in_a2 == CW'(1);
   assign b_x2l = in_a1 == '0 && in_a2 == '1;
   assign gen = !(b_x1h || b_x1l || b_x2h || b_x2l);
   assign full = cnt == NW'(MAX_GEN);
   assign wr = state == LOAD && in_valid && gen && !full;
   assign inv = x1_lo > x1_hi || x2_lo > x2_hi;
   // The first point is evaluated in the LOAD cycle that sees in_valid fall.
   assign eval = state == SCAN || (state == LOAD && !in_valid && !inv);
   assign p1 = state == SCAN ? x1 : x1_lo;
   assign p2 = state == SCAN ? x2 : x2_lo;
   assign last = p1 == x1_hi && p2 == x2_hi;
   assign nx1 = p1 == x1_hi ? x1_lo : p1 + BW'(1);
   assign nx2 = p1 == x1_hi ? p2 + BW'(1) : p2;
   assign obj = OW'(c1) * OW'(p1) + OW'(c2) * OW'(p2);
   assign take = &ok && (!found || (mode ? obj < best : obj > best));
   for (genvar g = 0; g < MAX_GEN; g++) begin : slot
      logic signed [CW-1:0] a1, a2;
      logic signed [BW-1:0] b;
      always_ff @(posedge clk)
         if (wr && cnt == NW'(g)) begin
            a1 <= in_a1;
            a2 <= in_a2;
            b  <= in_b;
         end
      assign ok[g] = cnt <= NW'(g) || OW'(a1) * OW'(p1) + OW'(a2) * OW'(p2) <= OW'(b);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         mode <= 1'b0;
         c1 <= '0;
         c2 <= '0;
         x1_lo <= '0;
         x1_hi <= '0;
         x2_lo <= '0;
         x2_hi <= '0;
         x1 <= '0;
         x2 <= '0;
         cnt <= '0;
         ovf <= 1'b0;
         found <= 1'b0;
         best <= '0;
         bx1 <= '0;
         bx2 <= '0;
         out_valid <= 1'b0;
         out_feasible <= 1'b0;
         out_overflow <= 1'b0;
         out_value <= '0;
         out_x1 <= '0;
         out_x2 <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               mode <= in_mode;
               c1 <= in_a1;
               c2 <= in_a2;
               state <= LOAD;
            end
            LOAD: if (in_valid) begin
               if (b_x1h) x1_hi <= in_b;
               else if (b_x1l) x1_lo <= -in_b;
               else if (b_x2h) x2_hi <= in_b;
               else if (b_x2l) x2_lo <= -in_b;
               else if (full) ovf <= 1'b1;
               else cnt <= cnt + NW'(1);
            end else if (inv) begin
               state <= DONE;
               out_valid <= 1'b1;
               out_feasible <= 1'b0;
               out_overflow <= ovf;
               out_value <= '0;
               out_x1 <= '0;
               out_x2 <= '0;
            end
            DONE: begin
               state <= IDLE;
               out_valid <= 1'b0;
               x1_lo <= '0;
               x1_hi <= '0;
               x2_lo <= '0;
               x2_hi <= '0;
               cnt <= '0;
               ovf <= 1'b0;
               found <= 1'b0;
            end
            default: ;
         endcase
         if (eval) begin
            if (take) begin
               found <= 1'b1;
               best <= obj;
               bx1 <= p1;
               bx2 <= p2;
            end
            if (last) begin
               state <= DONE;
               out_valid <= 1'b1;
               out_feasible <= found || take;
               out_overflow <= ovf;
               out_value <= take ? obj : found ? best : '0;
               out_x1 <= take ? p1 : found ? bx1 : '0;
               out_x2 <= take ? p2 : found ? bx2 : '0;
            end else begin
               state <= SCAN;
               x1 <= nx1;
               x2 <= nx2;
            end
         end
      end
endmodule

// File: tb/tb_lp_grid_solver.sv
// tb_lp_grid_solver: directed problems with hand-computed optima; a scoreboard
// queue holds expected results and a negedge monitor checks each out_valid.
module tb_lp_grid_solver;
   localparam int CW = 6, BW = 12, OW = CW + BW + 2;
   logic clk = 0, rst_n = 0, in_valid = 0, in_mode = 0;
   logic signed [CW-1:0] in_a1 = '0, in_a2 = '0;
   logic signed [BW-1:0] in_b = '0;
   logic out_valid, out_feasible, out_overflow;
   logic signed [OW-1:0] out_value;
   logic signed [BW-1:0] out_x1, out_x2;
   typedef struct {longint v; longint x1; longint x2; bit f; bit o; int cyc;} exp_t;
   typedef struct {int a1; int a2; int b;} beat_t;
   exp_t sb[$];
   beat_t beats[$];
   int cyc = 0, tests = 0, fails = 0;

   lp_grid_solver #(.CW(CW), .BW(BW), .MAX_GEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mode(in_mode),
      .in_a1(in_a1), .in_a2(in_a2), .in_b(in_b),
      .out_valid(out_valid), .out_feasible(out_feasible), .out_overflow(out_overflow),
      .out_value(out_value), .out_x1(out_x1), .out_x2(out_x2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string n, input longint a, input longint r);
      tests++;
      if (a != r) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", n, a, r, cyc);
      end
   endtask

   always @(negedge clk)
      if (rst_n && out_valid) begin : mon
         exp_t e;
         if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
         else begin
            e = sb.pop_front();
            chk("value", out_value, e.v);
            chk("x1", out_x1, e.x1);
            chk("x2", out_x2, e.x2);
            chk("feasible", out_feasible, e.f);
            chk("overflow", out_overflow, e.o);
            chk("latency_cycle", cyc, e.cyc);
         end
      end

   task automatic add(input int a1, input int a2, input int b);
      beats.push_back('{a1, a2, b});
   endtask

   // Later beats carry the inverted mode to show it is sampled only on the first beat.
   task automatic drive(input bit mode);
      foreach (beats[i]) begin
         in_valid = 1;
         in_mode = (i == 0) ? mode : !mode;
         in_a1 = CW'(beats[i].a1);
         in_a2 = CW'(beats[i].a2);
         in_b = BW'(beats[i].b);
         @(posedge clk); #1;
      end
      in_valid = 0;
      beats.delete();
   endtask

   task automatic run(input bit mode, input longint v, input longint x1, input longint x2,
                      input bit f, input bit o, input int p);
      int n = 0;
      drive(mode);
      sb.push_back('{v, x1, x2, f, o, cyc + p});
      while (sb.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk("result_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic chk_zero(input string n);
      chk({n, "_valid"}, out_valid, 0);
      chk({n, "_feasible"}, out_feasible, 0);
      chk({n, "_overflow"}, out_overflow, 0);
      chk({n, "_value"}, out_value, 0);
      chk({n, "_x1"}, out_x1, 0);
      chk({n, "_x2"}, out_x2, 0);
   endtask

   task automatic t1_beats(input int a1, input int a2);
      add(a1, a2, 77);
      add(1, 0, 4); add(-1, 0, 0); add(0, 1, 3); add(0, -1, 0);
      add(1, 1, 5); add(2, 1, 8);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      rst_n = 1;
      @(posedge clk); #1;
      t1_beats(3, 2);
      run(0, 13, 3, 2, 1, 0, 20);
      t1_beats(1, -1);
      run(1, -3, 0, 3, 1, 0, 20);
      add(1, 1, 0); add(1, 0, 3); add(0, 1, 3); add(1, 1, -1);
      run(0, 0, 0, 0, 0, 0, 16);
      add(1, 0, 0); add(1, 0, 1); add(-1, 0, -3);
      run(0, 0, 0, 0, 0, 0, 1);
      add(1, 1, 0); add(1, 0, 2); add(0, 1, 2); add(1, 1, 2);
      run(0, 2, 2, 0, 1, 0, 9);
      add(1, 1, 0); add(1, 0, 3); add(0, 1, 3);
      add(1, 1, 6); add(2, 0, 6); add(0, 2, 6); add(1, 2, 9); add(1, 1, 1);
      run(0, 6, 3, 3, 1, 1, 16);
      add(2, 3, 0); add(-1, 0, 2); add(1, 0, 1); add(0, -1, 1); add(0, 1, 1); add(-1, -1, 2);
      run(1, -5, -1, -1, 1, 0, 12);
      add(5, -7, 0);
      run(0, 0, 0, 0, 1, 0, 1);
      t1_beats(3, 2);
      drive(0);
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 0;
      #1;
      chk_zero("abort");
      @(posedge clk); #1;
      rst_n = 1;
      repeat (40) begin @(posedge clk); #1; end
      add(1, 1, 0); add(1, 0, 2); add(0, 1, 2); add(1, 1, 2);
      run(0, 2, 2, 0, 1, 0, 9);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end
endmodule
